// File: rtl/restoring_divider_ctrl.sv
// Sequential unsigned restoring divider controller, one quotient bit per clock.
// Drives an external add_sub (A - B via C_in=1) and restores on borrow (C_out=0).
module restoring_divider_ctrl #(
  parameter int                WIDTH  = 4,
  parameter logic [WIDTH-1:0]  DIV0_Q = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_cin,
  input  logic [WIDTH-1:0] as_s,
  input  logic             as_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] trial;
  logic             in_calc;

  assign in_calc = (state_q == S_CALC);
  assign trial   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  assign ready       = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign as_a        = in_calc ? trial : '0;
  assign as_b        = in_calc ? d_q : '0;
  assign as_cin      = in_calc;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = DIV0_Q;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // No borrow keeps the difference; a borrow restores the trial remainder.
        if (as_cout) begin
          r_d = as_s;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Bench for restoring_divider_ctrl with a behavioural add_sub on the as_* ports.
// Expected results are queued at stimulus time and compared when done pulses.
module tb_restoring_divider_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend, divisor;
  logic             ready, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;
  logic [WIDTH-1:0] as_a, as_b, as_s;
  logic             as_cin, as_cout;
  logic [WIDTH:0]   as_sum;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  // add_sub: S = A + ~B + C_in, C_out is the carry (1 = no borrow when subtracting)
  assign as_sum  = {1'b0, as_a} + {1'b0, ~as_b} + {{WIDTH{1'b0}}, as_cin};
  assign as_s    = as_sum[WIDTH-1:0];
  assign as_cout = as_sum[WIDTH];

  restoring_divider_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .as_a(as_a), .as_b(as_b), .as_cin(as_cin),
    .as_s(as_s), .as_cout(as_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("quotient", {28'd0, quotient}, {28'd0, e.q});
        check("remainder", {28'd0, remainder}, {28'd0, e.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = {WIDTH{1'b1}}; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Counts rising edges until done is seen; CALC cycles must show as_cin=1 and ready=0.
  task automatic wait_done(input bit drop_start, input bit calc_expected, output int n);
    bit cin_bad;
    cin_bad = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      n++;
      if (drop_start && i == 0) begin
        #1 start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        if (as_cin !== 1'b0 || ready !== 1'b0) cin_bad = 1'b1;
        if (calc_expected) check("cin_ready_calc", {31'd0, cin_bad}, 32'd0);
        return;
      end
      if (calc_expected && (as_cin !== 1'b1 || ready !== 1'b0)) cin_bad = 1'b1;
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int exp_lat);
    int n;
    @(negedge clk);
    check("ready_before", {31'd0, ready}, 32'd1);
    start = 1'b1; dividend = a; divisor = b;
    sb_q.push_back(model(a, b));
    wait_done(1'b1, b != 0, n);
    check("latency", n, exp_lat);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {28'd0, quotient}, 32'd0);
    check("rst_r", {28'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_cin", {31'd0, as_cin}, 32'd0);
    rst_n = 1'b1;

    run_op(4'd13, 4'd3, 5);
    @(negedge clk);
    check("hold_q", {28'd0, quotient}, 32'd4);

    // Back-to-back with start held high across both operations
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    sb_q.push_back(model(4'd15, 4'd1));
    sb_q.push_back(model(4'd5, 4'd9));
    @(posedge clk);
    #1 dividend = 4'd5; divisor = 4'd9;
    @(negedge clk);
    check("ready_calc", {31'd0, ready}, 32'd0);
    wait_done(1'b0, 1'b1, n);
    check("b2b_lat1", n, 4);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, 1'b1, n);
    check("b2b_lat2", n, 4);

    run_op(4'd9, 4'd0, 1);
    run_op(4'd15, 4'd15, 5);
    run_op(4'd0, 4'd7, 5);

    // start pulse with different operands mid-CALC is ignored
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    sb_q.push_back(model(4'd12, 4'd5));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 1'b1, n);

    // Reset during the second CALC cycle aborts the operation
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q", {28'd0, quotient}, 32'd0);
    check("abort_r", {28'd0, remainder}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    check("abort_cin", {31'd0, as_cin}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
